// File: rtl/fsm_path_driver.sv
// Stimulus driver and flag checker for the 4-bit sequence-detector FSM:
// resets it, plays a per-mode a/b program, then grades the s/bs/f flags.
module fsm_path_driver #(
  parameter int unsigned RST_CYCLES = 1,
  parameter int unsigned TIMEOUT    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  output logic       dut_rst,
  output logic       a,
  output logic       b,
  input  logic       s_in,
  input  logic       bs_in,
  input  logic       f_in,
  output logic       busy,
  output logic       done,
  output logic       pass
);

  typedef enum logic [2:0] {IDLE, RST, STEP, WAIT, FIN} state_t;

  state_t     state, state_n;
  logic [1:0] mode_q, mode_n;
  logic [2:0] step, step_n, step_inc;
  logic [3:0] cnt, cnt_n;
  logic       fail, fail_n;
  logic       dut_rst_n, a_n, b_n, busy_n, done_n, pass_n;
  logic       exp_flag, bad_flag, fail_now;

  function automatic logic [1:0] step_ab(input logic [1:0] m, input logic [2:0] j);
    step_ab = 2'b00;
    case (m)
      2'd0:    if (j == 3'd5 || j == 3'd6) step_ab = 2'b10;
      2'd2:    if (j == 3'd2) step_ab = 2'b01;
      default: step_ab = 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] last_step(input logic [1:0] m);
    case (m)
      2'd0:    last_step = 3'd6;
      2'd1:    last_step = 3'd5;
      default: last_step = 3'd2;
    endcase
  endfunction

  always_comb begin
    exp_flag = 1'b0;
    bad_flag = 1'b0;
    case (mode_q)
      2'd0:    begin exp_flag = f_in;  bad_flag = s_in | bs_in; end
      2'd1:    begin exp_flag = bs_in; bad_flag = s_in | f_in;  end
      default: begin exp_flag = s_in;  bad_flag = f_in | bs_in; end
    endcase
  end

  assign step_inc = step + 3'd1;
  assign fail_now = fail | bad_flag;

  always_comb begin
    state_n   = state;
    mode_n    = mode_q;
    step_n    = step;
    cnt_n     = cnt;
    fail_n    = fail;
    dut_rst_n = dut_rst;
    a_n       = a;
    b_n       = b;
    busy_n    = busy;
    done_n    = 1'b0;
    pass_n    = pass;
    case (state)
      IDLE: begin
        if (start) begin
          if (mode == 2'd3) begin
            state_n = FIN;
            done_n  = 1'b1;
            pass_n  = 1'b0;
          end else begin
            state_n   = RST;
            mode_n    = mode;
            busy_n    = 1'b1;
            dut_rst_n = 1'b1;
            a_n       = 1'b0;
            b_n       = 1'b0;
            cnt_n     = '0;
            step_n    = '0;
            fail_n    = 1'b0;
          end
        end
      end
      RST: begin
        if (cnt == 4'(RST_CYCLES - 1)) begin
          // step 0 values are loaded on the same edge that releases dut_rst
          state_n    = STEP;
          dut_rst_n  = 1'b0;
          step_n     = '0;
          {a_n, b_n} = step_ab(mode_q, 3'd0);
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      STEP: begin
        fail_n = fail_now;
        if (step == last_step(mode_q)) begin
          state_n = WAIT;
          a_n     = 1'b0;
          b_n     = 1'b0;
          cnt_n   = '0;
        end else begin
          step_n     = step_inc;
          {a_n, b_n} = step_ab(mode_q, step_inc);
        end
      end
      WAIT: begin
        fail_n = fail_now;
        if (exp_flag) begin
          state_n = FIN;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          pass_n  = ~fail_now;
        end else if (cnt == 4'(TIMEOUT - 1)) begin
          state_n = FIN;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          pass_n  = 1'b0;
        end else if (cnt != '1) begin
          cnt_n = cnt + 4'd1;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mode_q  <= '0;
      step    <= '0;
      cnt     <= '0;
      fail    <= 1'b0;
      dut_rst <= 1'b0;
      a       <= 1'b0;
      b       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      state   <= state_n;
      mode_q  <= mode_n;
      step    <= step_n;
      cnt     <= cnt_n;
      fail    <= fail_n;
      dut_rst <= dut_rst_n;
      a       <= a_n;
      b       <= b_n;
      busy    <= busy_n;
      done    <= done_n;
      pass    <= pass_n;
    end
  end

endmodule
